input_debounce: RTL and testbench

//  Front-end conditioner for raw asynchronous 1-bit inputs (buttons, slow external lines).

---
 rtl/input_debounce_pkg.sv | 21 ++
 rtl/input_debounce_sync_ff.sv | 32 +++
 rtl/input_debounce.sv | 103 ++++++++++
 tb/tb_input_debounce.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_debounce_pkg
//  Brief    : Shared state encoding and parameter defaults for the input
//             debouncer and its synchroniser.
//  Revision : 1.0  initial release
// ============================================================================
package input_debounce_pkg;

    // Qualification FSM states; one bit is enough for the two-state machine.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    // Default synchroniser depth and qualification length.
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;

endpackage : input_debounce_pkg
`default_nettype wire

// File: rtl/input_debounce_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Brief    : Generic multi-flop synchroniser for one asynchronous bit.
//             Stage 0 is the only flop that samples the raw input.
//  Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw level through the chain; reset parks every stage at the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= {STAGES{RESET_LEVEL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : input_debounce
//  Brief    : Synchronises a raw asynchronous level and only lets a change
//             through once it has been stable for STABLE_CYCLES consecutive
//             clock edges. Reports qualification in progress (busy) and
//             abandoned candidates (glitch).
//  Revision : 1.0  initial release
// ============================================================================
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic busy,
    output logic glitch
);

    // Terminal count: the edge at which a held change is accepted.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             w_sync;
    logic             w_mismatch;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_busy;
    logic             r_glitch;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (w_sync)
    );

    // A candidate change exists whenever the synchronised level differs from the output.
    assign w_mismatch = (w_sync != r_out);

    // Qualification FSM with counter and registered out/busy/glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_out    <= RESET_LEVEL;
            r_busy   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_glitch <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mismatch) begin
                        r_state <= ST_QUALIFY;
                        r_cnt   <= c_CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_QUALIFY: begin
                    if (!w_mismatch) begin
                        // Bounced back: drop the partial count entirely.
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_glitch <= 1'b1;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_busy   <= 1'b0;
                        r_out    <= w_sync;
                    end else begin
                        r_cnt    <= r_cnt + c_CNT_ONE;
                        r_busy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out    = r_out;
    assign busy   = r_busy;
    assign glitch = r_glitch;

endmodule : input_debounce
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_debounce
//  Brief    : Directed self-checking bench for input_debounce with
//             SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_debounce;

    logic clk;
    logic reset;
    logic in;
    logic out;
    logic busy;
    logic glitch;

    int checks = 0;
    int errors = 0;

    input_debounce #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .out    (out),
        .busy   (busy),
        .glitch (glitch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=done");
        $fatal(1, "timeout");
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int   glitches;
        int   toggles;
        int   first_rise;
        logic prev_out;

        // 1: reset for three edges with in low.
        reset = 1'b1;
        in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_out_%0d", i), out, 1'b0);
            check($sformatf("rst_busy_%0d", i), busy, 1'b0);
            check($sformatf("rst_glitch_%0d", i), glitch, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("post_rst_out_%0d", i), out, 1'b0);
            check($sformatf("post_rst_busy_%0d", i), busy, 1'b0);
        end

        // 2: clean 0->1, busy after E0+2..E0+4, out after E0+5.
        in = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            step();
            check($sformatf("rise_busy_E%0d", i), busy, (i >= 2 && i <= 4));
            check($sformatf("rise_out_E%0d", i), out, (i >= 5));
            check($sformatf("rise_glitch_E%0d", i), glitch, 1'b0);
        end

        // Return to 0 cleanly.
        in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("fall_out", out, 1'b0);
        check("fall_busy", busy, 1'b0);

        // 3: high for two edges then low; one glitch after E0+4.
        for (int i = 0; i <= 7; i++) begin
            in = (i < 2);
            step();
            check($sformatf("bnc_glitch_E%0d", i), glitch, (i == 4));
            check($sformatf("bnc_busy_E%0d", i), busy, (i == 2 || i == 3));
            check($sformatf("bnc_out_E%0d", i), out, 1'b0);
        end

        // 4: reset during qualification with cnt=2 (after E0+3).
        in = 1'b1;
        for (int i = 0; i <= 3; i++) step();
        check("midq_busy", busy, 1'b1);
        reset = 1'b1;
        in    = 1'b0;
        step();
        check("midq_rst_out", out, 1'b0);
        check("midq_rst_busy", busy, 1'b0);
        check("midq_rst_glitch", glitch, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("midq_after_out_%0d", i), out, 1'b0);
            check($sformatf("midq_after_glitch_%0d", i), glitch, 1'b0);
        end

        // 5: in held high across reset release; out rises 5 edges after release.
        reset = 1'b1;
        in    = 1'b1;
        step();
        step();
        check("rel_in_rst_out", out, 1'b0);
        reset = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            step();
            check($sformatf("rel_out_E%0d", i), out, (i >= 5));
        end

        // Back to 0 before the bounce train.
        in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pre6_out", out, 1'b0);

        // 6: bounce 1,0,1,0 then 1 held; bench-side double-edge detector
        // counts changes of out seen at successive edges.
        glitches   = 0;
        toggles    = 0;
        first_rise = -1;
        prev_out   = out;
        for (int i = 0; i < 16; i++) begin
            case (i)
                1, 3:    in = 1'b0;
                default: in = 1'b1;
            endcase
            step();
            if (glitch === 1'b1) glitches++;
            if (out !== prev_out) begin
                toggles++;
                if (first_rise < 0 && out === 1'b1) first_rise = i;
            end
            prev_out = out;
        end
        check_int("train_glitches", glitches, 2);
        check_int("train_detector_pulses", toggles, 1);
        check_int("train_rise_edge", first_rise, 9);
        check("train_final_out", out, 1'b1);
        check("train_final_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_input_debounce
`default_nettype wire
